// File: rtl/axi_pkg.sv
// Shared AXI types for the SRAM responder: response codes, burst types,
// responder FSM states and the AW/AR round-robin grant helper.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ
  } rsp_state_t;

  // Returns {aw_grant, ar_grant}; wprio selects the winner when both are valid.
  function automatic logic [1:0] rr_grant(input logic aw_v, input logic ar_v,
                                          input logic wprio);
    logic gw;
    gw = aw_v & (~ar_v | wprio);
    return {gw, ar_v & ~gw};
  endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Byte-enabled single-port word array with a registered read port.
// No reset, so contents survive a reset pulse; swap for an SRAM macro here.
module axi_sram_array #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 1024,
  parameter int ADDR_BITS  = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_BITS-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate serving INCR bursts from an internal SRAM array.
// Reads and writes are serialized through one FSM; all handshake outputs are registers.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  rsp_state_t              state_q;
  logic                    awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
  logic                    wprio_q, bad_burst_q, werr_q;
  logic [ID_WIDTH-1:0]     bid_q, rid_q;
  resp_t                   bresp_q, rresp_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [8:0]              rem_q;

  logic                    aw_hs, ar_hs, w_hs;
  logic [ADDR_WIDTH-1:0]   aw_idx, ar_idx, idx_nx, rd_idx;
  logic                    w_last_beat, w_oob, w_beat_err, r_oob_nx;
  logic [1:0]              gnt_d;
  logic                    arr_we, arr_re;
  logic [MAW-1:0]          arr_addr;
  logic [DATA_WIDTH-1:0]   arr_rdata;
  logic                    unused_size;

  assign unused_size = ^{awsize_i, arsize_i};

  assign aw_hs       = awvalid_i & awready_q;
  assign ar_hs       = arvalid_i & arready_q;
  assign w_hs        = wvalid_i & wready_q;
  assign aw_idx      = awaddr_i >> OFF;
  assign ar_idx      = araddr_i >> OFF;
  assign idx_nx      = idx_q + ADDR_WIDTH'(1);
  assign w_last_beat = (rem_q == 9'd1);
  assign w_oob       = (idx_q >= DEPTH_A);
  assign w_beat_err  = w_oob | (wlast_i != w_last_beat);
  assign gnt_d       = rr_grant(awvalid_i, arvalid_i, wprio_q);

  // Read address: the AR start word in IDLE, otherwise the word after the current beat.
  assign rd_idx   = (state_q == ST_IDLE) ? ar_idx : idx_nx;
  assign r_oob_nx = (rd_idx >= DEPTH_A);
  assign arr_we   = w_hs & ~bad_burst_q & ~w_oob;
  assign arr_re   = ar_hs | ((state_q == ST_READ) & rready_i & ~rlast_q);
  assign arr_addr = (state_q == ST_WRITE) ? idx_q[MAW-1:0] : rd_idx[MAW-1:0];

  axi_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_BITS  (MAW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (arr_addr),
    .wdata_i (wdata_i),
    .be_i    (wstrb_i),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      wprio_q     <= 1'b1;
      bad_burst_q <= 1'b0;
      werr_q      <= 1'b0;
      bid_q       <= '0;
      rid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      idx_q       <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (aw_hs) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            bid_q       <= awid_i;
            idx_q       <= aw_idx;
            rem_q       <= {1'b0, awlen_i} + 9'd1;
            bad_burst_q <= (awburst_i != BURST_INCR);
            werr_q      <= 1'b0;
            wprio_q     <= 1'b0;
            state_q     <= ST_WRITE;
          end else if (ar_hs) begin
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b1;
            rid_q       <= arid_i;
            idx_q       <= ar_idx;
            rem_q       <= {1'b0, arlen_i} + 9'd1;
            bad_burst_q <= (arburst_i != BURST_INCR);
            rresp_q     <= ((arburst_i != BURST_INCR) || r_oob_nx) ? RESP_SLVERR : RESP_OKAY;
            rlast_q     <= (arlen_i == 8'd0);
            wprio_q     <= 1'b1;
            state_q     <= ST_READ;
          end else begin
            {awready_q, arready_q} <= gnt_d;
          end
        end
        ST_WRITE: begin
          if (w_hs) begin
            idx_q <= idx_nx;
            rem_q <= rem_q - 9'd1;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q | w_beat_err | bad_burst_q) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_WRESP;
            end else begin
              werr_q <= werr_q | w_beat_err;
            end
          end
        end
        ST_WRESP: begin
          if (bready_i) begin
            bvalid_q               <= 1'b0;
            {awready_q, arready_q} <= gnt_d;
            state_q                <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rready_i) begin
            if (rlast_q) begin
              rvalid_q               <= 1'b0;
              rlast_q                <= 1'b0;
              rresp_q                <= RESP_OKAY;
              {awready_q, arready_q} <= gnt_d;
              state_q                <= ST_IDLE;
            end else begin
              idx_q   <= idx_nx;
              rem_q   <= rem_q - 9'd1;
              rlast_q <= (rem_q == 9'd2);
              rresp_q <= (bad_burst_q | r_oob_nx) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign awready_o = awready_q;
  assign arready_o = arready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign rvalid_o  = rvalid_q;
  assign rid_o     = rid_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  // Array read register only updates on handshakes, so this mux is hold-stable.
  assign rdata_o   = (rvalid_q && rresp_q == RESP_OKAY) ? arr_rdata : '0;

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI4 slave (responder) that serves INCR bursts from an internal single-port SRAM array, terminating one AXI4 master port. It is the subordinate end of the master-side read/write engines used by the fetch and load/store paths, and a synthesizable replacement for the behavioural RAM model in master/slave loopback benches. Reads and writes are serialized through one state machine; the array is accessed only in that state machine's active states.

## Interface
- DATA_WIDTH, 256: data bus width in bits; must be a power of two, ≥32.
- ADDR_WIDTH, 32: byte address width.
- ID_WIDTH, 8: AXI ID width.
- MEM_DEPTH, 1024: number of DATA_WIDTH words in the array.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- AW channel  in: AWVALID, AWID[ID_WIDTH], AWADDR[ADDR_WIDTH], AWLEN[8], AWSIZE[3], AWBURST[2]  out: AWREADY.
- W channel  in: WVALID, WDATA[DATA_WIDTH], WSTRB[DATA_WIDTH/8], WLAST  out: WREADY.
- B channel  out: BVALID, BID[ID_WIDTH], BRESP[2]  in: BREADY.
- AR channel  in: ARVALID, ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2]  out: ARREADY.
- R channel  out: RVALID, RID, RDATA[DATA_WIDTH], RRESP[2], RLAST  in: RREADY.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ. Reset → IDLE.
- IDLE: AWREADY/ARREADY asserted only for the granted channel. If both AWVALID and ARVALID are high, round-robin priority applies: write wins first after reset, then priority toggles after each granted transaction. A lone valid is granted immediately.
- Word index = addr >> log2(DATA_WIDTH/8). Unaligned start addresses are rounded down. AWSIZE/ARSIZE are ignored; every beat is a full-width beat. Index increments by 1 per beat.
- Beat count = LEN+1 (1..256), held in a 9-bit counter.
- WRITE: WREADY=1. On each W handshake, bytes with WSTRB set are written to mem[index]. The burst ends on beat LEN+1 regardless of WLAST.
- BRESP=SLVERR (2'b10) if any of the following occurs, otherwise OKAY:
  - WLAST is asserted on a beat other than the final beat;
  - WLAST is deasserted on the final beat;
  - a beat index is ≥ MEM_DEPTH (that beat is not written);
  - AWBURST ≠ INCR (2'b01) (no beats are written for the whole burst).
- WRESP: BVALID=1 with BID=latched AWID. Held until BREADY, then → IDLE.
- READ: RVALID with RDATA=mem[index], RID=latched ARID, RLAST on the final beat.
  - RRESP=SLVERR and RDATA=0 for any beat with index ≥ MEM_DEPTH, or for every beat when ARBURST ≠ INCR.
  - RRESP=OKAY otherwise.
  - After the final R handshake → IDLE.
- R outputs remain stable while RVALID && !RREADY (AXI hold rule). B outputs behave the same way.

## Timing
- Reset values of all outputs: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP = 2'b00; BID, RID, RDATA = 0.
- Reset asserted mid-burst: all outputs go to reset values immediately, the FSM returns to IDLE, and the array contents are preserved.
- AW handshake at cycle N: WREADY=1 from N+1. Last W handshake at cycle M: BVALID=1 at M+1.
- AR handshake at cycle N: RVALID=1 at N+1 with beat 0.
  - The array read is registered: on each R handshake the next word is loaded, so RVALID stays high for back-to-back beats. Peak rate is 1 beat/cycle.
- After the BREADY or final-RREADY handshake at cycle K, the FSM is in IDLE at K+1. The next AWREADY/ARREADY is asserted at K+1, so there is a 1-cycle minimum gap between transactions.
- No combinational path from any input to any output. All READY/VALID outputs are registers.

## Structure
- Shared package (axi_pkg): resp_t (OKAY=2'b00, SLVERR=2'b10), burst_t (FIXED/INCR/WRAP), responder FSM state enum.
- One sub-module: axi_sram_array. It is the byte-enabled single-port array with a registered read port, kept separate so it can be swapped for an SRAM macro.

## Test plan
- Single beat: AW addr=0x40, LEN=0, WSTRB=all ones, WDATA=0xA5…; then AR addr=0x40, LEN=0. Required: BRESP=OKAY, RDATA=0xA5…, RLAST=1, RRESP=OKAY.
- 4-beat INCR write at 0x100 with per-beat distinct data, then 4-beat read with RREADY toggling every other cycle. Required: 4 beats in order, RLAST only on beat 3, outputs stable while stalled.
- Partial strobe: write 0xFF… full, then WSTRB=0x1 with data 0x00…. Required: readback byte 0 = 0x00, all other bytes 0xFF.
- Simultaneous AWVALID and ARVALID from reset, twice. Required: first grant is write; second grant is read.
- Error cases, each required to return SLVERR:
  - write at index MEM_DEPTH: BRESP=SLVERR, memory unchanged;
  - AWBURST=WRAP: BRESP=SLVERR, no writes;
  - early WLAST on beat 1 of LEN=3: BRESP=SLVERR after 4 beats;
  - read past the end: RRESP=SLVERR, RDATA=0.
- Reset pulse during beat 2 of a 4-beat read. Required: RVALID=0 immediately, IDLE after release, and a following read returns the previously written data.
